// File: rtl/seq_chk_pkg.sv
// Shared types and helpers for the down-counter / doubling-stage checker.
package seq_chk_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StSync  = 2'd1,
      StCheck = 2'd2,
      StFail  = 2'd3
   } seq_state_e;

   // Bit positions inside fail_kind.
   localparam int unsigned FailKindCnt = 0;
   localparam int unsigned FailKindDbl = 1;

   // Caller narrows the result to its own width, which gives the mod-2^W wrap.
   function automatic logic [31:0] exp_next_count(input logic [31:0] prev);
      return prev - 32'd1;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear has priority over increment.
module sat_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_b,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] value
);

   logic [W-1:0] value_d, value_q;

   always_comb begin
      value_d = value_q;
      if (clr) begin
         value_d = '0;
      end else if (inc && (value_q != {W{1'b1}})) begin
         value_d = value_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;

endmodule

// File: rtl/seq_checker.sv
// Checks that count steps down by one each cycle and that doubleCount tracks
// twice the previous count; logs mismatches with pulse, sticky flag, counters.
module seq_checker
   import seq_chk_pkg::*;
#(
   parameter int unsigned WIDTH       = 4,
   parameter int unsigned ERR_CNT_W   = 8,
   parameter int unsigned CYC_CNT_W   = 16,
   parameter bit          STOP_ON_ERR = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst_b,
   input  logic                 enable,
   input  logic                 clear,
   input  logic [WIDTH-1:0]     count_in,
   input  logic [WIDTH:0]       dbl_in,
   output logic                 checking,
   output logic                 error_pulse,
   output logic                 err_sticky,
   output logic [ERR_CNT_W-1:0] err_count,
   output logic [CYC_CNT_W-1:0] cycle_count,
   output logic [CYC_CNT_W-1:0] fail_cycle,
   output logic [1:0]           fail_kind
);

   seq_state_e           state_d, state_q;
   logic [WIDTH-1:0]     prev_count_d, prev_count_q;
   logic [WIDTH-1:0]     exp_count;
   logic [WIDTH:0]       exp_dbl;
   logic                 cnt_bad, dbl_bad, mismatch;
   logic                 checking_d, checking_q;
   logic                 error_pulse_d, error_pulse_q;
   logic                 err_sticky_d, err_sticky_q;
   logic [CYC_CNT_W-1:0] fail_cycle_d, fail_cycle_q;
   logic [1:0]           fail_kind_d, fail_kind_q;
   logic                 err_inc, cyc_inc;

   assign exp_count = WIDTH'(exp_next_count(32'(prev_count_q)));
   assign exp_dbl   = {prev_count_q, 1'b0};
   assign cnt_bad   = (count_in != exp_count);
   assign dbl_bad   = (dbl_in != exp_dbl);
   assign mismatch  = cnt_bad | dbl_bad;

   always_comb begin
      state_d       = state_q;
      prev_count_d  = prev_count_q;
      error_pulse_d = 1'b0;
      err_sticky_d  = err_sticky_q;
      fail_cycle_d  = fail_cycle_q;
      fail_kind_d   = fail_kind_q;
      err_inc       = 1'b0;
      cyc_inc       = 1'b0;

      if (clear) begin
         err_sticky_d = 1'b0;
         fail_cycle_d = '0;
         fail_kind_d  = '0;
         state_d      = enable ? StSync : StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (enable) state_d = StSync;
            end
            StSync: begin
               if (!enable) begin
                  state_d = StIdle;
               end else begin
                  // Skip the first sample: dbl is unreset in the stage after reset.
                  prev_count_d = count_in;
                  state_d      = StCheck;
               end
            end
            StCheck: begin
               if (!enable) begin
                  state_d = StIdle;
               end else begin
                  // Always follow the observed count so one glitch is logged once.
                  prev_count_d = count_in;
                  cyc_inc      = 1'b1;
                  if (mismatch) begin
                     error_pulse_d = 1'b1;
                     err_sticky_d  = 1'b1;
                     err_inc       = 1'b1;
                     if (!err_sticky_q) begin
                        fail_cycle_d              = cycle_count;
                        fail_kind_d               = '0;
                        fail_kind_d[FailKindCnt] = cnt_bad;
                        fail_kind_d[FailKindDbl] = dbl_bad;
                     end
                     if (STOP_ON_ERR) state_d = StFail;
                  end
               end
            end
            StFail: begin
               state_d = StFail;
            end
         endcase
      end

      checking_d = (state_d == StCheck);
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q       <= StIdle;
         prev_count_q  <= '0;
         checking_q    <= 1'b0;
         error_pulse_q <= 1'b0;
         err_sticky_q  <= 1'b0;
         fail_cycle_q  <= '0;
         fail_kind_q   <= '0;
      end else begin
         state_q       <= state_d;
         prev_count_q  <= prev_count_d;
         checking_q    <= checking_d;
         error_pulse_q <= error_pulse_d;
         err_sticky_q  <= err_sticky_d;
         fail_cycle_q  <= fail_cycle_d;
         fail_kind_q   <= fail_kind_d;
      end
   end

   sat_counter #(
      .W (ERR_CNT_W)
   ) u_err_cnt (
      .clk   (clk),
      .rst_b (rst_b),
      .inc   (err_inc),
      .clr   (clear),
      .value (err_count)
   );

   sat_counter #(
      .W (CYC_CNT_W)
   ) u_cyc_cnt (
      .clk   (clk),
      .rst_b (rst_b),
      .inc   (cyc_inc),
      .clr   (clear),
      .value (cycle_count)
   );

   assign checking    = checking_q;
   assign error_pulse = error_pulse_q;
   assign err_sticky  = err_sticky_q;
   assign fail_cycle  = fail_cycle_q;
   assign fail_kind   = fail_kind_q;

endmodule

// File: tb/tb_seq_checker.sv
// Scoreboard bench: stimulus queues hand-computed expected outputs, a monitor compares them.
module tb_seq_checker;

   typedef struct packed {
      logic        chk;
      logic        pulse;
      logic        sticky;
      logic [7:0]  errc;
      logic [15:0] cycc;
      logic [15:0] fcyc;
      logic [1:0]  fkind;
   } obs_t;

   typedef struct {
      int   tag;
      obs_t o;
   } exp_t;

   logic clk = 1'b0;
   logic rst_b;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   event async_ev;
   exp_t q0[$];
   exp_t q1[$];

   // dut0: resynchronising, 2-bit error counter
   logic        en0, clr0, chk0, pulse0, sticky0;
   logic [3:0]  cnt0;
   logic [4:0]  dbl0;
   logic [1:0]  errc0, fkind0;
   logic [15:0] cycc0, fcyc0;

   // dut1: stop-on-error, 3-bit cycle counter
   logic        en1, clr1, chk1, pulse1, sticky1;
   logic [3:0]  cnt1;
   logic [4:0]  dbl1;
   logic [7:0]  errc1;
   logic [1:0]  fkind1;
   logic [2:0]  cycc1, fcyc1;

   seq_checker #(
      .WIDTH       (4),
      .ERR_CNT_W   (2),
      .CYC_CNT_W   (16),
      .STOP_ON_ERR (1'b0)
   ) dut0 (
      .clk         (clk),
      .rst_b       (rst_b),
      .enable      (en0),
      .clear       (clr0),
      .count_in    (cnt0),
      .dbl_in      (dbl0),
      .checking    (chk0),
      .error_pulse (pulse0),
      .err_sticky  (sticky0),
      .err_count   (errc0),
      .cycle_count (cycc0),
      .fail_cycle  (fcyc0),
      .fail_kind   (fkind0)
   );

   seq_checker #(
      .WIDTH       (4),
      .ERR_CNT_W   (8),
      .CYC_CNT_W   (3),
      .STOP_ON_ERR (1'b1)
   ) dut1 (
      .clk         (clk),
      .rst_b       (rst_b),
      .enable      (en1),
      .clear       (clr1),
      .count_in    (cnt1),
      .dbl_in      (dbl1),
      .checking    (chk1),
      .error_pulse (pulse1),
      .err_sticky  (sticky1),
      .err_count   (errc1),
      .cycle_count (cycc1),
      .fail_cycle  (fcyc1),
      .fail_kind   (fkind1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic obs_t mk(input logic chk, input logic pulse, input logic sticky,
                               input int errc, input int cycc, input int fcyc, input int fkind);
      obs_t o;
      o.chk    = chk;
      o.pulse  = pulse;
      o.sticky = sticky;
      o.errc   = 8'(errc);
      o.cycc   = 16'(cycc);
      o.fcyc   = 16'(fcyc);
      o.fkind  = 2'(fkind);
      return o;
   endfunction

   function automatic obs_t obs0();
      return mk(chk0, pulse0, sticky0, int'(errc0), int'(cycc0), int'(fcyc0), int'(fkind0));
   endfunction

   function automatic obs_t obs1();
      return mk(chk1, pulse1, sticky1, int'(errc1), int'(cycc1), int'(fcyc1), int'(fkind1));
   endfunction

   task automatic compare(input string nm, input exp_t e, input obs_t a);
      checks++;
      if (a !== e.o) begin
         failures++;
         $display("FAIL %s cyc=%0d actual chk=%0b pulse=%0b sticky=%0b errc=%0d cycc=%0d fcyc=%0d kind=%0b required chk=%0b pulse=%0b sticky=%0b errc=%0d cycc=%0d fcyc=%0d kind=%0b",
                  nm, e.tag, a.chk, a.pulse, a.sticky, a.errc, a.cycc, a.fcyc, a.fkind,
                  e.o.chk, e.o.pulse, e.o.sticky, e.o.errc, e.o.cycc, e.o.fcyc, e.o.fkind);
      end
   endtask

   // Monitor: compares every expectation whose cycle has come.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk or async_ev);
         while (q0.size() != 0 && q0[0].tag <= cyc) begin
            e = q0.pop_front();
            compare("dut0", e, obs0());
         end
         while (q1.size() != 0 && q1[0].tag <= cyc) begin
            e = q1.pop_front();
            compare("dut1", e, obs1());
         end
      end
   end

   task automatic push(input int which, input int tag, input obs_t o);
      exp_t e;
      e.tag = tag;
      e.o   = o;
      if (which == 0) q0.push_back(e);
      else q1.push_back(e);
   endtask

   // Apply one input vector for one edge; expected outputs are those after that edge.
   task automatic v0(input logic en, input logic clr, input int cnt, input int dbl,
                     input logic chk, input logic pulse, input logic sticky,
                     input int errc, input int cycc, input int fcyc, input int fkind);
      en0  = en;
      clr0 = clr;
      cnt0 = 4'(cnt);
      dbl0 = 5'(dbl);
      push(0, cyc + 1, mk(chk, pulse, sticky, errc, cycc, fcyc, fkind));
      @(posedge clk);
      #1;
   endtask

   task automatic v1(input logic en, input logic clr, input int cnt, input int dbl,
                     input logic chk, input logic pulse, input logic sticky,
                     input int errc, input int cycc, input int fcyc, input int fkind);
      en1  = en;
      clr1 = clr;
      cnt1 = 4'(cnt);
      dbl1 = 5'(dbl);
      push(1, cyc + 1, mk(chk, pulse, sticky, errc, cycc, fcyc, fkind));
      @(posedge clk);
      #1;
   endtask

   initial begin
      int c;
      int wait_cnt;
      rst_b = 1'b0;
      en0 = 1'b0; clr0 = 1'b0; cnt0 = '0; dbl0 = '0;
      en1 = 1'b0; clr1 = 1'b0; cnt1 = '0; dbl1 = '0;
      @(posedge clk);
      #1;
      push(0, cyc, mk(0, 0, 0, 0, 0, 0, 0));
      push(1, cyc, mk(0, 0, 0, 0, 0, 0, 0));
      @(posedge clk);
      #1;
      rst_b = 1'b1;

      // Ideal stage, including wrap 0 -> 15 with dbl 0
      v0(1, 0, 15, 0,  0, 0, 0, 0, 0, 0, 0);
      v0(1, 0, 14, 30, 1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 16; i++) begin
         c = (13 - i + 16) % 16;
         v0(1, 0, c, 2 * ((c + 1) % 16), 1, 0, 0, 0, i + 1, 0, 0);
      end
      // Count glitch: 9 where 13 expected, stage continues from 9
      v0(1, 0, 9, 28,  1, 1, 1, 1, 17, 16, 1);
      v0(1, 0, 8, 18,  1, 0, 1, 1, 18, 16, 1);
      v0(1, 0, 7, 16,  1, 0, 1, 1, 19, 16, 1);
      // Dbl-only error after the first: capture fields stay put
      v0(1, 0, 6, 15,  1, 1, 1, 2, 20, 16, 1);
      v0(1, 0, 5, 12,  1, 0, 1, 2, 21, 16, 1);
      // Clear coincident with a mismatch
      v0(1, 1, 0, 10,  0, 0, 0, 0, 0, 0, 0);
      v0(1, 0, 3, 0,   1, 0, 0, 0, 0, 0, 0);
      // Five count errors on a 2-bit error counter
      v0(1, 0, 3, 6,   1, 1, 1, 1, 1, 0, 1);
      v0(1, 0, 3, 6,   1, 1, 1, 2, 2, 0, 1);
      v0(1, 0, 3, 6,   1, 1, 1, 3, 3, 0, 1);
      v0(1, 0, 3, 6,   1, 1, 1, 3, 4, 0, 1);
      v0(1, 0, 3, 6,   1, 1, 1, 3, 5, 0, 1);
      v0(1, 0, 2, 6,   1, 0, 1, 3, 6, 0, 1);
      // Disable retains results; re-enable passes through SYNC
      v0(0, 0, 1, 4,   0, 0, 1, 3, 6, 0, 1);
      v0(0, 0, 9, 9,   0, 0, 1, 3, 6, 0, 1);
      v0(1, 0, 7, 0,   0, 0, 1, 3, 6, 0, 1);
      v0(1, 0, 6, 0,   1, 0, 1, 3, 6, 0, 1);
      v0(1, 0, 5, 12,  1, 0, 1, 3, 7, 0, 1);
      // Build err_count = 2, then async reset mid-CHECK
      v0(1, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0);
      v0(1, 0, 4, 0,   1, 0, 0, 0, 0, 0, 0);
      v0(1, 0, 4, 8,   1, 1, 1, 1, 1, 0, 1);
      v0(1, 0, 2, 8,   1, 1, 1, 2, 2, 0, 1);
      @(negedge clk);
      #2;
      rst_b = 1'b0;
      push(0, cyc, mk(0, 0, 0, 0, 0, 0, 0));
      #1;
      ->async_ev;
      @(posedge clk);
      #1;
      v0(1, 0, 15, 0,  0, 0, 0, 0, 0, 0, 0);
      rst_b = 1'b1;
      v0(1, 0, 15, 0,  0, 0, 0, 0, 0, 0, 0);
      v0(1, 0, 14, 7,  1, 0, 0, 0, 0, 0, 0);
      v0(1, 0, 13, 28, 1, 0, 0, 0, 1, 0, 0);
      en0 = 1'b0;

      // Stop-on-error: dbl-only mismatch enters FAIL and freezes
      v1(1, 0, 15, 0,  0, 0, 0, 0, 0, 0, 0);
      v1(1, 0, 14, 3,  1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         c = 13 - i;
         v1(1, 0, c, 2 * (c + 1), 1, 0, 0, 0, i + 1, 0, 0);
      end
      v1(1, 0, 8, 17,  0, 1, 1, 1, 6, 5, 2);
      v1(1, 0, 7, 16,  0, 0, 1, 1, 6, 5, 2);
      v1(0, 0, 6, 14,  0, 0, 1, 1, 6, 5, 2);
      v1(1, 0, 0, 0,   0, 0, 1, 1, 6, 5, 2);
      v1(1, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0);
      v1(1, 0, 5, 0,   1, 0, 0, 0, 0, 0, 0);
      // cycle_count saturates at 7 across the 0 -> 15 wrap
      for (int i = 0; i < 8; i++) begin
         c = (4 - i + 16) % 16;
         v1(1, 0, c, 2 * ((c + 1) % 16), 1, 0, 0, 0, (i + 1 > 7) ? 7 : i + 1, 0, 0);
      end
      en1 = 1'b0;

      wait_cnt = 0;
      while ((q0.size() != 0 || q1.size() != 0) && wait_cnt < 20) begin
         @(posedge clk);
         wait_cnt++;
      end
      if (q0.size() != 0 || q1.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d required=0", q0.size() + q1.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
